// File: rtl/mode_ctrl_if.sv
// mode_ctrl_if
// Bundles the transport/mode controller's button levels, datapath addresses
// and mode outputs into one port.
//   master : button levels and adc/dac addresses in, mode outputs observed
//   slave  : the controller itself (reads buttons/addresses, drives modes)
// Signals:
//   play_btn, record_btn, stop_btn     debounced transport button levels
//   spd_up_btn, spd_dn_btn, interp_btn debounced speed/interpolation levels
//   rec_addr, play_addr                current adc write / dac read address
//   play, record                       datapath enables
//   slow, fast, slowmethod             dac speed controls
//   rec_len                            number of valid recorded words
//   state_o                            00 IDLE, 01 RECORD, 10 PLAY, 11 PAUSE
interface mode_ctrl_if #(
  parameter int AW = 18
);
  logic          play_btn;
  logic          record_btn;
  logic          stop_btn;
  logic          spd_up_btn;
  logic          spd_dn_btn;
  logic          interp_btn;
  logic [AW-1:0] rec_addr;
  logic [AW-1:0] play_addr;
  logic          play;
  logic          record;
  logic [3:0]    slow;
  logic [3:0]    fast;
  logic          slowmethod;
  logic [AW-1:0] rec_len;
  logic [1:0]    state_o;

  modport master (
    output play_btn, record_btn, stop_btn, spd_up_btn, spd_dn_btn, interp_btn,
    output rec_addr, play_addr,
    input  play, record, slow, fast, slowmethod, rec_len, state_o
  );

  modport slave (
    input  play_btn, record_btn, stop_btn, spd_up_btn, spd_dn_btn, interp_btn,
    input  rec_addr, play_addr,
    output play, record, slow, fast, slowmethod, rec_len, state_o
  );
endinterface

// File: rtl/mode_ctrl.sv
// mode_ctrl
// Transport/mode controller of the recorder. Turns debounced button levels
// into one-cycle events, runs the IDLE/RECORD/PLAY/PAUSE machine, keeps the
// recorded length so playback ends at the last valid word, and derives the
// dac speed controls from a saturating signed speed index.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    mode_ctrl_if.slave: button levels, rec/play addresses in;
//          play, record, slow, fast, slowmethod, rec_len, state_o out
module mode_ctrl #(
  parameter int            AW       = 18,
  parameter logic [AW-1:0] ADDR_MAX = 18'h3FFFF,
  parameter int            MAX_RATE = 8
) (
  input  logic       clk,
  input  logic       reset,
  mode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RECORD = 2'b01,
    PLAY   = 2'b10,
    PAUSE  = 2'b11
  } state_t;

  // Length stored when recording runs into the end of memory: one past the
  // last usable word, clamped so it still fits in AW bits.
  localparam logic [AW:0]   ADDR_END = {1'b0, ADDR_MAX} + {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] REC_FULL = ADDR_END[AW] ? {AW{1'b1}} : ADDR_END[AW-1:0];

  localparam logic signed [4:0] SPD_MAX = 5'(MAX_RATE - 1);
  localparam logic signed [4:0] SPD_MIN = -SPD_MAX;

  state_t            state, state_nxt;
  logic [5:0]        btn, btn_prev, ev;
  logic              play_ev, record_ev, stop_ev, spd_up_ev, spd_dn_ev, interp_ev;
  logic              len_load;
  logic [AW-1:0]     len_val;
  logic [AW-1:0]     rec_len_q;
  logic              play_q, record_q;
  logic signed [4:0] spd;
  logic [3:0]        spd_abs, rate;
  logic [3:0]        slow_q, fast_q;
  logic              slowmethod_q;

  assign btn = {bus.interp_btn, bus.spd_dn_btn, bus.spd_up_btn,
                bus.stop_btn, bus.record_btn, bus.play_btn};
  assign ev  = btn & ~btn_prev;

  assign play_ev   = ev[0];
  assign record_ev = ev[1];
  assign stop_ev   = ev[2];
  assign spd_up_ev = ev[3];
  assign spd_dn_ev = ev[4];
  assign interp_ev = ev[5];

  // Rising-edge history. Cleared by reset so a button still held when reset
  // releases counts as a fresh press on the first clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_prev <= '0;
    end else begin
      btn_prev <= btn;
    end
  end

  // Next transport state. Within each state stop wins over record, which
  // wins over play. Leaving RECORD also decides what length gets stored.
  always_comb begin
    state_nxt = state;
    len_load  = 1'b0;
    len_val   = bus.rec_addr;
    case (state)
      IDLE: begin
        if (!stop_ev) begin
          if (record_ev) begin
            state_nxt = RECORD;
          end else if (play_ev && rec_len_q != '0) begin
            state_nxt = PLAY;
          end
        end
      end
      RECORD: begin
        if (stop_ev || record_ev) begin
          state_nxt = IDLE;
          len_load  = 1'b1;
        end else if (bus.rec_addr == ADDR_MAX) begin
          state_nxt = IDLE;
          len_load  = 1'b1;
          len_val   = REC_FULL;
        end
      end
      PLAY: begin
        if (stop_ev) begin
          state_nxt = IDLE;
        end else if (record_ev) begin
          state_nxt = RECORD;
        end else if (play_ev) begin
          state_nxt = PAUSE;
        end else if (bus.play_addr >= rec_len_q) begin
          state_nxt = IDLE;
        end
      end
      PAUSE: begin
        if (stop_ev) begin
          state_nxt = IDLE;
        end else if (record_ev) begin
          state_nxt = RECORD;
        end else if (play_ev) begin
          state_nxt = PLAY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register with enables decoded from the next state, so the enables
  // switch in the same cycle as state_o. rec_len only moves on RECORD exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      play_q    <= 1'b0;
      record_q  <= 1'b0;
      rec_len_q <= '0;
    end else begin
      state    <= state_nxt;
      play_q   <= (state_nxt == PLAY);
      record_q <= (state_nxt == RECORD);
      if (len_load) begin
        rec_len_q <= len_val;
      end
    end
  end

  assign spd_abs = spd[4] ? 4'(-spd) : spd[3:0];
  assign rate    = spd_abs + 4'd1;

  // Speed index and its mapping onto slow/fast. Positive index speeds up,
  // negative slows down; simultaneous up and down presses cancel. The
  // mapping is registered from the index, so it trails it by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spd          <= '0;
      slow_q       <= 4'd1;
      fast_q       <= 4'd1;
      slowmethod_q <= 1'b0;
    end else begin
      if (spd_up_ev && !spd_dn_ev && spd != SPD_MAX) begin
        spd <= spd + 5'sd1;
      end else if (spd_dn_ev && !spd_up_ev && spd != SPD_MIN) begin
        spd <= spd - 5'sd1;
      end
      slow_q       <= spd[4] ? rate : 4'd1;
      fast_q       <= (!spd[4] && spd != '0) ? rate : 4'd1;
      slowmethod_q <= slowmethod_q ^ interp_ev;
    end
  end

  assign bus.play       = play_q;
  assign bus.record     = record_q;
  assign bus.slow       = slow_q;
  assign bus.fast       = fast_q;
  assign bus.slowmethod = slowmethod_q;
  assign bus.rec_len    = rec_len_q;
  assign bus.state_o    = state;

endmodule
